// File: rtl/wb_regfile_sb_pkg.sv
// Shared pipeline definitions for the write-back register file and its
// pending-write scoreboard: data/index widths, counter width and the
// write-back result-select encoding.
package wb_regfile_sb_pkg;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int AW    = $clog2(NREG);
    localparam int CNT_W = 2;

    // Largest value a per-register in-flight writer counter can hold
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Write-back result select: execute result or load data
    typedef enum logic {
        WB_SEL_RES = 1'b0,
        WB_SEL_MEM = 1'b1
    } wb_sel_e;

    // Picks the value committed by the write-back stage
    function automatic logic [XLEN-1:0] wb_mux(
        input logic            sel,
        input logic [XLEN-1:0] res,
        input logic [XLEN-1:0] mem
    );
        return (wb_sel_e'(sel) == WB_SEL_MEM) ? mem : res;
    endfunction

endpackage

// File: rtl/wb_regfile_sb_scoreboard.sv
// Per-register in-flight writer counters and RAW-hazard detection.
// A counter goes up when an instruction claiming the register issues and
// down when a claiming instruction retires; flush clears every counter.
// Counters saturate and set a sticky overflow flag.
// Optional macro WB_REGFILE_BYPASS_EN: the last in-flight writer retiring in
// the same cycle does not cause a stall (its data is forwarded by the top).
module wb_scoreboard
    import wb_regfile_sb_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_claim,
    input  logic [AW-1:0] wb_rd,
    input  logic          id_issue,
    input  logic          id_claim,
    input  logic [AW-1:0] id_rd,
    input  logic [AW-1:0] id_rs1,
    input  logic [AW-1:0] id_rs2,
    input  logic          flush,
    output logic          stall,
    output logic          sb_overflow
);

    logic [CNT_W-1:0] w_cnt [NREG];
    logic [NREG-1:0]  w_sat_hit;
    logic             w_stall;
    logic             w_hz1;
    logic             w_hz2;
    logic             r_overflow;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                // r0 is never written, so it never has writers in flight
                assign w_cnt[gi]     = '0;
                assign w_sat_hit[gi] = 1'b0;
            end else begin : g_reg
                logic [CNT_W-1:0] r_cnt;
                logic             w_inc;
                logic             w_dec;

                // A stalled issue has not left ID, so it claims nothing yet
                assign w_inc = id_issue && id_claim && !w_stall && (id_rd == AW'(gi));
                assign w_dec = wb_claim && (wb_rd == AW'(gi));

                // Counter update: flush wins, simultaneous inc/dec cancel,
                // saturate at the top and floor at zero
                always_ff @(posedge clk) begin
                    if (reset || flush) begin
                        r_cnt <= '0;
                    end else if (w_inc && !w_dec) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_dec && !w_inc) begin
                        if (r_cnt != '0) begin
                            r_cnt <= r_cnt - CNT_W'(1);
                        end
                    end
                end

                assign w_cnt[gi]     = r_cnt;
                assign w_sat_hit[gi] = w_inc && !w_dec && (r_cnt == CNT_MAX);
            end
        end
    endgenerate

    // Source hazards are judged on the counts before this cycle's issue
    always_comb begin
        w_hz1 = (id_rs1 != '0) && (w_cnt[id_rs1] != '0);
        w_hz2 = (id_rs2 != '0) && (w_cnt[id_rs2] != '0);
`ifdef WB_REGFILE_BYPASS_EN
        // Only writer left is retiring now and its result is forwarded
        if ((w_cnt[id_rs1] == CNT_W'(1)) && wb_claim && (wb_rd == id_rs1)) begin
            w_hz1 = 1'b0;
        end
        if ((w_cnt[id_rs2] == CNT_W'(1)) && wb_claim && (wb_rd == id_rs2)) begin
            w_hz2 = 1'b0;
        end
`endif
    end

    assign w_stall = !reset && id_issue && (w_hz1 || w_hz2);
    assign stall   = w_stall;

    // Sticky overflow: set when an increment meets a saturated counter,
    // cleared only by reset; a flush cancels that cycle's increments
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (!flush && (|w_sat_hit)) begin
            r_overflow <= 1'b1;
        end
    end

    assign sb_overflow = r_overflow;

endmodule

// File: rtl/wb_regfile_sb.sv
// Write-back register file with pending-write scoreboard. Commits the
// selected WB result, serves two combinational ID read ports and reports
// RAW stalls from the scoreboard sub-module.
// Optional macro WB_REGFILE_BYPASS_EN: same-cycle WB-to-read forwarding.
module wb_regfile_sb
    import wb_regfile_sb_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            wb_we,
    input  logic            wb_claim,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_res,
    input  logic [XLEN-1:0] wb_mem_data,
    input  logic            wb_sel,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            id_issue,
    input  logic            id_claim,
    input  logic [AW-1:0]   id_rd,
    input  logic            flush,
    output logic            stall,
    output logic            sb_overflow
);

    logic [XLEN-1:0] w_wdata;
    logic            w_wr_en;
    logic [XLEN-1:0] w_regs    [NREG];
    logic [AW-1:0]   w_rs_idx  [2];
    logic [XLEN-1:0] w_rs_data [2];

    assign w_wdata = wb_mux(wb_sel, wb_res, wb_mem_data);
    assign w_wr_en = wb_we && (wb_rd != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign w_regs[gi] = '0;
            end else begin : g_store
                logic [XLEN-1:0] r_val;

                // Commit the selected result when this register is the target
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_val <= '0;
                    end else if (w_wr_en && (wb_rd == AW'(gi))) begin
                        r_val <= w_wdata;
                    end
                end

                assign w_regs[gi] = r_val;
            end
        end
    endgenerate

    assign w_rs_idx[0] = id_rs1;
    assign w_rs_idx[1] = id_rs2;

    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            // Read port: r0 and reset read zero, optional WB forwarding
            always_comb begin
                w_rs_data[gi] = '0;
                if (!reset && (w_rs_idx[gi] != '0)) begin
                    w_rs_data[gi] = w_regs[w_rs_idx[gi]];
`ifdef WB_REGFILE_BYPASS_EN
                    if (wb_we && (wb_rd == w_rs_idx[gi])) begin
                        w_rs_data[gi] = w_wdata;
                    end
`endif
                end
            end
        end
    endgenerate

    assign rs1_data = w_rs_data[0];
    assign rs2_data = w_rs_data[1];

    wb_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .wb_claim    (wb_claim),
        .wb_rd       (wb_rd),
        .id_issue    (id_issue),
        .id_claim    (id_claim),
        .id_rd       (id_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .flush       (flush),
        .stall       (stall),
        .sb_overflow (sb_overflow)
    );

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Scoreboard-style bench for wb_regfile_sb: each stimulus cycle pushes its
// hand-computed expectations into a queue and a negedge monitor pops and
// compares them against the DUT outputs of that cycle.
module tb_wb_regfile_sb;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        wb_we;
    logic        wb_claim;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic [31:0] wb_mem_data;
    logic        wb_sel;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        id_issue;
    logic        id_claim;
    logic [4:0]  id_rd;
    logic        flush;
    logic        stall;
    logic        sb_overflow;

    typedef struct {
        string       name;
        bit          c_rs1;
        logic [31:0] e_rs1;
        bit          c_rs2;
        logic [31:0] e_rs2;
        bit          c_st;
        logic        e_st;
        bit          c_ov;
        logic        e_ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    wb_regfile_sb dut (
        .clk         (clk),
        .reset       (reset),
        .wb_we       (wb_we),
        .wb_claim    (wb_claim),
        .wb_rd       (wb_rd),
        .wb_res      (wb_res),
        .wb_mem_data (wb_mem_data),
        .wb_sel      (wb_sel),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .id_issue    (id_issue),
        .id_claim    (id_claim),
        .id_rd       (id_rd),
        .flush       (flush),
        .stall       (stall),
        .sb_overflow (sb_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cmp(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    // Monitor: compare this cycle's outputs against the queued expectation
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.c_rs1) cmp(e.name, "rs1_data", rs1_data, e.e_rs1);
            if (e.c_rs2) cmp(e.name, "rs2_data", rs2_data, e.e_rs2);
            if (e.c_st)  cmp(e.name, "stall", {31'd0, stall}, {31'd0, e.e_st});
            if (e.c_ov)  cmp(e.name, "sb_overflow", {31'd0, sb_overflow}, {31'd0, e.e_ov});
            $display("chk %-12s rs1=%h rs2=%h stall=%b ovf=%b", e.name, rs1_data, rs2_data, stall, sb_overflow);
        end
    end

    task automatic clr();
        reset = 1'b0; wb_we = 1'b0; wb_claim = 1'b0; wb_rd = '0;
        wb_res = '0; wb_mem_data = '0; wb_sel = 1'b0;
        id_rs1 = '0; id_rs2 = '0; id_issue = 1'b0; id_claim = 1'b0;
        id_rd = '0; flush = 1'b0;
    endtask

    task automatic drv_id(input bit iss, input bit clm, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2);
        id_issue = iss; id_claim = clm; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
    endtask

    task automatic drv_wb(input bit we, input bit clm, input logic [4:0] rd,
                          input logic [31:0] res, input logic [31:0] mem, input bit sel);
        wb_we = we; wb_claim = clm; wb_rd = rd; wb_res = res; wb_mem_data = mem; wb_sel = sel;
    endtask

    // Queue expectations for the cycle just driven, then advance one clock
    task automatic step(input string name,
                        input bit c1, input logic [31:0] e1,
                        input bit c2, input logic [31:0] e2,
                        input bit cs, input logic es,
                        input bit co, input logic eo);
        exp_t e;
        e.name = name;
        e.c_rs1 = c1; e.e_rs1 = e1; e.c_rs2 = c2; e.e_rs2 = e2;
        e.c_st = cs;  e.e_st = es;  e.c_ov = co;  e.e_ov = eo;
        if (c1 || c2 || cs || co) exp_q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset behaviour and write/read of r5
        reset = 1'b1; drv_id(1, 0, 0, 5, 0);
        step("rst_hold", 1, 0, 0, 0, 1, 0, 1, 0);
        drv_wb(1, 0, 5, 32'hDEAD_BEEF, 0, 0); drv_id(0, 0, 0, 5, 0);
        step("wr_r5", 1, BYP ? 32'hDEAD_BEEF : 32'h0, 0, 0, 0, 0, 0, 0);
        drv_id(0, 0, 0, 5, 0);
        step("rd_r5", 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
        reset = 1'b1; drv_id(0, 0, 0, 5, 0);
        step("rst_mid", 1, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 5, 5);
        step("post_rst", 1, 0, 1, 0, 1, 0, 1, 0);

        // r0 writes dropped and never counted
        drv_wb(1, 0, 0, 32'h1234, 0, 0); drv_id(1, 1, 0, 0, 0);
        step("wr_r0", 1, 0, 1, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 0, 0);
        step("rd_r0", 1, 0, 1, 0, 1, 0, 0, 0);

        // I1 writes r3, I2 reads it two cycles later
        drv_id(1, 1, 3, 0, 0);
        step("i1_issue", 0, 0, 0, 0, 1, 0, 0, 0);
        step("gap", 0, 0, 0, 0, 0, 0, 0, 0);
        drv_id(1, 0, 0, 3, 0);
        step("i2_stall", 0, 0, 0, 0, 1, 1, 0, 0);
        drv_id(1, 0, 0, 3, 0);
        step("i2_hold", 0, 0, 0, 0, 1, 1, 0, 0);
        drv_wb(1, 1, 3, 32'h1111_1111, 32'hCAFE_0001, 1); drv_id(1, 0, 0, 3, 0);
        step("i1_retire", 1, BYP ? 32'hCAFE_0001 : 32'h0, 0, 0, 1, !BYP, 0, 0);
        drv_id(1, 0, 0, 3, 0);
        step("i2_go", 1, 32'hCAFE_0001, 0, 0, 1, 0, 0, 0);

        // Two writers to r7, second retires predicated off
        drv_wb(1, 0, 7, 32'h77, 0, 0); drv_id(1, 1, 7, 0, 0);
        step("w1_issue", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 1, 7, 0, 0);
        step("w2_issue", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 0, 7);
        step("rd7_stall", 0, 0, 1, 32'h77, 1, 1, 0, 0);
        drv_wb(1, 1, 7, 32'h7001, 0, 0); drv_id(1, 0, 0, 0, 7);
        step("w1_retire", 0, 0, 1, BYP ? 32'h7001 : 32'h77, 1, 1, 0, 0);
        drv_wb(0, 1, 7, 32'hBAD, 32'hBAD, 0); drv_id(1, 0, 0, 0, 7);
        step("w2_predoff", 0, 0, 1, 32'h7001, 1, !BYP, 0, 0);
        drv_id(1, 0, 0, 0, 7);
        step("rd7_go", 0, 0, 1, 32'h7001, 1, 0, 0, 0);

        // Destination equal to own source uses the pre-increment count
        drv_id(1, 1, 7, 7, 0);
        step("self_src", 1, 32'h7001, 0, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 7, 0);
        step("self_dep", 1, 32'h7001, 0, 0, 1, 1, 0, 0);
        drv_wb(0, 1, 7, 32'hBAD, 0, 0); drv_id(1, 0, 0, 7, 0);
        step("self_ret", 1, 32'h7001, 0, 0, 1, !BYP, 0, 0);

        // Saturation of r9 and sticky overflow; stalled claim of r11
        for (int i = 0; i < 4; i++) begin
            drv_id(1, 1, 9, 0, 0);
            step("sat_inc", 0, 0, 0, 0, 1, 0, 1, 0);
        end
        drv_id(1, 1, 11, 9, 0);
        step("sat_stall", 0, 0, 0, 0, 1, 1, 1, 1);
        drv_wb(0, 1, 9, 0, 0, 0); drv_id(1, 0, 0, 9, 0);
        step("sat_ret1", 0, 0, 0, 0, 1, 1, 0, 0);
        drv_wb(0, 1, 9, 0, 0, 0); drv_id(1, 0, 0, 9, 0);
        step("sat_ret2", 0, 0, 0, 0, 1, 1, 0, 0);
        drv_wb(0, 1, 9, 0, 0, 0); drv_id(1, 0, 0, 9, 0);
        step("sat_ret3", 0, 0, 0, 0, 1, !BYP, 0, 0);
        drv_id(1, 0, 0, 9, 11);
        step("sat_clear", 0, 0, 0, 0, 1, 0, 1, 1);

        // Flush with cnt[r4]=2 and a simultaneous issue to r4
        drv_id(1, 1, 4, 0, 0);
        step("r4_inc1", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 1, 4, 0, 0);
        step("r4_inc2", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 4, 0);
        step("r4_busy", 0, 0, 0, 0, 1, 1, 0, 0);
        flush = 1'b1; drv_id(1, 1, 4, 0, 0);
        step("flush", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 4, 0);
        step("post_flush", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_wb(0, 1, 4, 0, 0, 0); drv_id(1, 0, 0, 4, 0);
        step("floor_dec", 0, 0, 0, 0, 1, 0, 0, 0);
        drv_id(1, 0, 0, 4, 0);
        step("floor_chk", 0, 0, 0, 0, 1, 0, 1, 1);

        // Overflow cleared only by reset
        reset = 1'b1;
        step("rst_final", 0, 0, 0, 0, 0, 0, 0, 0);
        step("ovf_clr", 0, 0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
- Consumer end of the MEM->WB interface: write-back register file plus per-register pending-write scoreboard.
- Accepts the registered WB-stage signals (destination, ALU result, memory data, result select, predicate-gated write enable).
- Commits the selected result to a 32-entry register file.
- Serves two ID-stage read ports and raises a RAW-hazard stall for sources that still have in-flight writers between ID and WB.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- AW, 5, register index width; must equal clog2(NREG).
- CNT_W, 2, per-register in-flight writer counter width; saturates at 2^CNT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wb_we  in  1  commit write this cycle; already gated by predicate
- wb_claim  in  1  retiring instruction claimed wb_rd at issue; independent of predicate
- wb_rd  in  AW  write-back destination index
- wb_res  in  XLEN  ALU/execute result
- wb_mem_data  in  XLEN  load data
- wb_sel  in  1  0 selects wb_res, 1 selects wb_mem_data
- id_rs1  in  AW  source 1 index
- id_rs2  in  AW  source 2 index
- rs1_data  out  XLEN  source 1 value (combinational)
- rs2_data  out  XLEN  source 2 value (combinational)
- id_issue  in  1  ID stage attempts to issue this cycle
- id_claim  in  1  issuing instruction writes a register
- id_rd  in  AW  destination index of the issuing instruction
- flush  in  1  pipeline flush; clears all scoreboard counters
- stall  out  1  RAW hazard; the ID stage must hold
- sb_overflow  out  1  sticky flag; an increment hit a saturated counter

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. On reset, all registers, all counters and sb_overflow are cleared to 0. During and after reset, rs*_data = 0 and stall = 0.
- Write data: wdata = wb_sel ? wb_mem_data : wb_res.
  - Write occurs at posedge when wb_we && wb_rd != 0.
  - Writes to r0 are dropped; r0 always reads 0.
- Reads:
  - rsN_data = 0 if id_rsN == 0.
  - Otherwise, if bypass is enabled (see Optional Feature), wb_we && wb_rd == id_rsN returns wdata in the same cycle.
  - Otherwise the stored value is returned.
- Scoreboard counter cnt[r], r = 1..NREG-1:
  - inc = id_issue && id_claim && !stall && id_rd == r
  - dec = wb_claim && wb_rd == r
  - inc && dec: cnt unchanged.
  - inc only: cnt+1; if cnt is at max, it holds max and sb_overflow is set.
  - dec only: cnt-1, floor at 0 (a decrement at 0 is ignored).
  - flush: all cnt go to 0, overriding inc/dec in the same cycle. Older writers already past the flush point decrement to the floor harmlessly. r0 is never counted.
- Hazard per source: hzN = id_rsN != 0 && cnt[id_rsN] != 0.
  - With bypass, hzN is cleared when cnt[id_rsN] == 1 && wb_claim && wb_rd == id_rsN; the last writer is retiring now and its data is forwarded.
  - stall = id_issue && (hz1 || hz2). Combinational; no latency.
- Predicated-off retire (wb_claim=1, wb_we=0): counter decrements, no register write. The consumer reads the old value.
- Issue with id_rd equal to one of its own sources: the hazard is evaluated on the pre-increment count.
- Stalled issue does not increment the counter.

Optional Feature:
- Macro WB_REGFILE_BYPASS_EN.
- Defined: same-cycle WB-to-read forwarding, and the last-writer hazard exemption described above.
- Undefined: reads return stored contents only. Any nonzero cnt stalls; the consumer issues one cycle after the final write-back.

Decomposition:
- Shared package (pipeline pkg): XLEN, NREG, AW, and the WB_SEL_RES/WB_SEL_MEM encodings.
- One sub-module: wb_scoreboard, holding the counters, inc/dec/flush logic, hazard compare and sb_overflow.
- Storage, write mux and read/bypass logic stay in the top module.

Test Plan:
- Reset mid-run, after writing r5=0xDEAD_BEEF -> next cycle rs1=5 reads 0; stall=0; sb_overflow=0.
- Write r0: wb_we=1, wb_rd=0, wb_res=0x1234 -> rs1=0 reads 0; no stall on r0.
- Issue I1 (rd=r3), 2 cycles later I2 reading r3 -> stall=1 until I1 retires.
  - Bypass build: stall drops in the retire cycle and rs1_data = I1 wdata (wb_sel=1, wb_mem_data=0xCAFE0001).
  - Non-bypass build: stall drops one cycle later.
- Two writers to r7 in flight (cnt=2), first retires -> stall held; second retires -> released. Predicated-off retire (wb_we=0, wb_claim=1) -> cnt decrements, r7 keeps old value.
- Four claims to r9 with no retire (CNT_W=2) -> cnt saturates at 3; sb_overflow=1 and stays set until reset.
- flush with cnt[r4]=2 and a simultaneous issue to r4 -> all counts 0 next cycle; a later wb_claim on r4 leaves cnt at 0.
